reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised register file for the processor datapath: 2^ADDR_W registers of DATA_W bits, one write port and two registered read ports, all on a single clock. It generalises the fixed 32-bit load register and the 5-to-32 decoders into one storage block with configurable width and depth. It adds three behaviours the plain register lacks: an optional hardwired-zero register 0, optional write-to-read bypass, and a read-valid strobe. It sits between instruction decode (register addresses) and the ALU operand muxes.

## Interface
- DATA_W, 32, register and data-port width in bits (1..64).
- ADDR_W, 5, address width; depth = 2^ADDR_W (1..6).
- ZERO_REG0, 1, when 1 register 0 ignores writes and always reads as 0.
- BYPASS, 1, when 1 a read of the address being written in the same cycle returns the new write data.
- RESET_VAL, 0, value loaded into every register on reset (DATA_W bits, truncated).

- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on rising CLK edge.
- READ  input  1  read request; samples both read addresses this edge.
- WRITE  input  1  write request; commits DATA_IN to ADDR_WR this edge.
- ADDR_R1  input  ADDR_W  read port 1 address.
- ADDR_R2  input  ADDR_W  read port 2 address.
- ADDR_WR  input  ADDR_W  write address.
- DATA_IN  input  DATA_W  write data.
- DATA_R1  output  DATA_W  registered read data, port 1.
- DATA_R2  output  DATA_W  registered read data, port 2.
- VALID  output  1  high for one cycle when DATA_R1/DATA_R2 carry fresh read data.

## Operation
- Reset (RESET=0 at edge): every register <= RESET_VAL, except register 0 <= 0 when ZERO_REG0=1. DATA_R1=0, DATA_R2=0, VALID=0. READ/WRITE ignored that edge. Reset has priority over all other actions.
- Write: WRITE=1 at edge -> reg[ADDR_WR] <= DATA_IN. The write is decoded one-hot over 2^ADDR_W enables. When ZERO_REG0=1 and ADDR_WR=0, the write is dropped.
- Read: READ=1 at edge -> DATA_R1 <= value(ADDR_R1), DATA_R2 <= value(ADDR_R2), VALID <= 1.
- READ=0 at edge -> DATA_R1/DATA_R2 hold previous values; VALID <= 0.
- value(a): 0 if ZERO_REG0=1 and a=0. Otherwise DATA_IN if BYPASS=1, WRITE=1 and ADDR_WR=a in the same edge. Otherwise the stored reg[a] (pre-write contents).
- Both ports may address the same register. Each port resolves independently and both return identical data.
- READ=1 and WRITE=1 together is legal. The write always commits; the read result follows the value() rule.
- No states beyond storage. VALID is a single flop tracking READ.

## Timing
- Write latency: 1 edge. Data is readable by a READ on the next edge, or on the same edge when BYPASS=1.
- Read latency: 1 edge from READ sampled to DATA_Rx/VALID valid. Back-to-back READs give VALID high continuously.
- Throughput: one write plus two reads per cycle.
- Reset mid-operation: a read or write on the reset edge is discarded. The outputs show 0 and VALID=0 starting the next cycle.
- First edge after RESET returns to 1 operates normally. There are no wait cycles.

## Test plan
- Reset: RESET=0 for 2 edges with RESET_VAL=32'hA5A5A5A5 -> DATA_R1=DATA_R2=0, VALID=0. A following read of r7/r0 returns 32'hA5A5A5A5 / 0 (ZERO_REG0=1).
- Write/read sweep: write r[i]=32'h1000_0000+i for i=1..31, then READ r[i] and r[31-i] -> exact values one edge later, VALID=1 each cycle. Repeat with DATA_W=16, ADDR_W=3.
- Register 0: WRITE r0=32'hFFFFFFFF, then READ r0 on both ports -> 0. With ZERO_REG0=0 the same sequence returns 32'hFFFFFFFF.
- Bypass: r5=32'h11111111; same edge WRITE r5=32'h22222222 and READ r5,r5 -> 32'h22222222 with BYPASS=1, 32'h11111111 with BYPASS=0. The next read returns 32'h22222222 in both builds.
- Hold: READ r3 (32'h33), then READ=0 for 3 edges while r3 is rewritten -> DATA_R1 stays 32'h33 and VALID=0 for those 3 cycles.
- Reset mid-operation: RESET=0 on the same edge as WRITE r9=32'h99 and READ r9 -> VALID=0, DATA_R1=0. The next READ of r9 returns RESET_VAL.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: 2^ADDR_W x DATA_W storage, one write port and two registered read ports.
// Optional hardwired-zero register 0, optional write-to-read bypass, and a read-valid strobe.
module reg_file_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          ZERO_REG0 = 1'b1,
    parameter bit          BYPASS    = 1'b1,
    parameter logic [63:0] RESET_VAL = 64'h0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDR_R1,
    input  logic [ADDR_W-1:0] ADDR_R2,
    input  logic [ADDR_W-1:0] ADDR_WR,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_R1,
    output logic [DATA_W-1:0] DATA_R2,
    output logic              VALID
);

    localparam int unsigned       DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] RST_V = DATA_W'(RESET_VAL);

    logic [DEPTH-1:0]  wr_en_c;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // One-hot write enables; register 0 never enabled when hardwired to zero
    always_comb begin
        wr_en_c = '0;
        if (WRITE) begin
            wr_en_c = DEPTH'(1) << ADDR_WR;
        end
        if (ZERO_REG0) begin
            wr_en_c[0] = 1'b0;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        localparam logic [DATA_W-1:0] INIT = (ZERO_REG0 && g == 0) ? '0 : RST_V;
        logic [DATA_W-1:0] q;

        always_ff @(posedge CLK) begin
            if (!RESET) begin
                q <= INIT;
            end else if (wr_en_c[g]) begin
                q <= DATA_IN;
            end
        end

        assign regs[g] = q;
    end

    // Zero register wins over bypass, bypass wins over the stored (pre-write) value
    function automatic logic [DATA_W-1:0] resolve(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (BYPASS && we && (wa == a)) begin
            v = wd;
        end
        if (ZERO_REG0 && (a == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd1_c = resolve(ADDR_R1, regs[ADDR_R1], WRITE, ADDR_WR, DATA_IN);
        rd2_c = resolve(ADDR_R2, regs[ADDR_R2], WRITE, ADDR_WR, DATA_IN);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
            VALID   <= 1'b0;
        end else begin
            VALID <= READ;
            if (READ) begin
                DATA_R1 <= rd1_c;
                DATA_R2 <= rd2_c;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three builds (zero-reg+bypass, plain, narrow 16x8)
// share one stimulus stream; expected outputs are queued per build and compared after each edge.
module tb_reg_file_param;

    typedef struct packed {
        logic        v;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [4:0]  addr_r1;
    logic [4:0]  addr_r2;
    logic [4:0]  addr_wr;
    logic [31:0] data_in;

    logic [31:0] r1_a, r2_a, r1_b, r2_b;
    logic [15:0] r1_c, r2_c;
    logic        v_a, v_b, v_c;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG0(1'b1), .BYPASS(1'b1),
                     .RESET_VAL(64'hA5A5A5A5)) dut_a (
        .CLK(clk), .RESET(reset), .READ(read), .WRITE(write),
        .ADDR_R1(addr_r1), .ADDR_R2(addr_r2), .ADDR_WR(addr_wr), .DATA_IN(data_in),
        .DATA_R1(r1_a), .DATA_R2(r2_a), .VALID(v_a)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG0(1'b0), .BYPASS(1'b0),
                     .RESET_VAL(64'hA5A5A5A5)) dut_b (
        .CLK(clk), .RESET(reset), .READ(read), .WRITE(write),
        .ADDR_R1(addr_r1), .ADDR_R2(addr_r2), .ADDR_WR(addr_wr), .DATA_IN(data_in),
        .DATA_R1(r1_b), .DATA_R2(r2_b), .VALID(v_b)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG0(1'b1), .BYPASS(1'b1),
                     .RESET_VAL(64'h5A5A)) dut_c (
        .CLK(clk), .RESET(reset), .READ(read), .WRITE(write),
        .ADDR_R1(addr_r1[2:0]), .ADDR_R2(addr_r2[2:0]), .ADDR_WR(addr_wr[2:0]),
        .DATA_IN(data_in[15:0]),
        .DATA_R1(r1_c), .DATA_R2(r2_c), .VALID(v_c)
    );

    // Drive one cycle of stimulus and return #1 after the sampling edge
    task automatic step(input logic rd, input logic wr, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] d);
        read    = rd;
        write   = wr;
        addr_r1 = a1;
        addr_r2 = a2;
        addr_wr = aw;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            qa.push_back('{1'b0, 32'h0, 32'h0});
            qb.push_back('{1'b0, 32'h0, 32'h0});
            qc.push_back('{1'b0, 32'h0, 32'h0});
            step(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 32'hDEAD_BEEF);
            e = qa.pop_front(); checks++;
            if ({v_a, r1_a, r2_a} !== e) begin
                errors++; $display("FAIL reset_a edge%0d got v=%b %h %h exp v=%b %h %h", k, v_a, r1_a, r2_a, e.v, e.r1, e.r2);
            end
            e = qb.pop_front(); checks++;
            if ({v_b, r1_b, r2_b} !== e) begin
                errors++; $display("FAIL reset_b edge%0d got v=%b %h %h exp v=%b %h %h", k, v_b, r1_b, r2_b, e.v, e.r1, e.r2);
            end
            e = qc.pop_front(); checks++;
            if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
                errors++; $display("FAIL reset_c edge%0d got v=%b %h %h exp v=%b %h %h", k, v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
            end
        end
        reset = 1'b1;
        qa.push_back('{1'b1, 32'hA5A5A5A5, 32'h0});
        qb.push_back('{1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5});
        qc.push_back('{1'b1, 32'h5A5A, 32'h0});
        step(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        e = qa.pop_front(); checks++;
        if ({v_a, r1_a, r2_a} !== e) begin
            errors++; $display("FAIL reset_read_a got v=%b %h %h exp v=%b %h %h", v_a, r1_a, r2_a, e.v, e.r1, e.r2);
        end
        e = qb.pop_front(); checks++;
        if ({v_b, r1_b, r2_b} !== e) begin
            errors++; $display("FAIL reset_read_b got v=%b %h %h exp v=%b %h %h", v_b, r1_b, r2_b, e.v, e.r1, e.r2);
        end
        e = qc.pop_front(); checks++;
        if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
            errors++; $display("FAIL reset_read_c got v=%b %h %h exp v=%b %h %h", v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
        end
    endtask

    task automatic test_sweep_wide;
        logic [4:0] lo;
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'h1000_0000 + 32'(i));
        end
        for (int i = 1; i < 32; i++) begin
            lo = 5'(31 - i);
            qa.push_back('{1'b1, 32'h1000_0000 + 32'(i), (lo == 5'd0) ? 32'h0 : 32'h1000_0000 + 32'(lo)});
            qb.push_back('{1'b1, 32'h1000_0000 + 32'(i), (lo == 5'd0) ? 32'hA5A5A5A5 : 32'h1000_0000 + 32'(lo)});
            step(1'b1, 1'b0, 5'(i), lo, 5'd0, 32'h0);
            e = qa.pop_front(); checks++;
            if ({v_a, r1_a, r2_a} !== e) begin
                errors++; $display("FAIL sweep_a i=%0d got v=%b %h %h exp v=%b %h %h", i, v_a, r1_a, r2_a, e.v, e.r1, e.r2);
            end
            e = qb.pop_front(); checks++;
            if ({v_b, r1_b, r2_b} !== e) begin
                errors++; $display("FAIL sweep_b i=%0d got v=%b %h %h exp v=%b %h %h", i, v_b, r1_b, r2_b, e.v, e.r1, e.r2);
            end
        end
    endtask

    task automatic test_sweep_narrow;
        logic [4:0] lo;
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'h0000_C000 + 32'(i));
        end
        for (int i = 1; i < 8; i++) begin
            lo = 5'(7 - i);
            qc.push_back('{1'b1, 32'hC000 + 32'(i), (lo == 5'd0) ? 32'h0 : 32'hC000 + 32'(lo)});
            step(1'b1, 1'b0, 5'(i), lo, 5'd0, 32'h0);
            e = qc.pop_front(); checks++;
            if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
                errors++; $display("FAIL sweep_c i=%0d got v=%b %h %h exp v=%b %h %h", i, v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
            end
        end
    endtask

    task automatic test_reg0;
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        qa.push_back('{1'b1, 32'h0, 32'h0});
        qb.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        qc.push_back('{1'b1, 32'h0, 32'h0});
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        e = qa.pop_front(); checks++;
        if ({v_a, r1_a, r2_a} !== e) begin
            errors++; $display("FAIL reg0_a got v=%b %h %h exp v=%b %h %h", v_a, r1_a, r2_a, e.v, e.r1, e.r2);
        end
        e = qb.pop_front(); checks++;
        if ({v_b, r1_b, r2_b} !== e) begin
            errors++; $display("FAIL reg0_b got v=%b %h %h exp v=%b %h %h", v_b, r1_b, r2_b, e.v, e.r1, e.r2);
        end
        e = qc.pop_front(); checks++;
        if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
            errors++; $display("FAIL reg0_c got v=%b %h %h exp v=%b %h %h", v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
        end
    endtask

    task automatic test_bypass;
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h1111_1111);
        for (int k = 0; k < 2; k++) begin
            qa.push_back('{1'b1, 32'h2222_2222, 32'h2222_2222});
            qb.push_back((k == 0) ? '{1'b1, 32'h1111_1111, 32'h1111_1111}
                                  : '{1'b1, 32'h2222_2222, 32'h2222_2222});
            qc.push_back('{1'b1, 32'h2222, 32'h2222});
            step(1'b1, (k == 0), 5'd5, 5'd5, 5'd5, 32'h2222_2222);
            e = qa.pop_front(); checks++;
            if ({v_a, r1_a, r2_a} !== e) begin
                errors++; $display("FAIL bypass_a k=%0d got v=%b %h %h exp v=%b %h %h", k, v_a, r1_a, r2_a, e.v, e.r1, e.r2);
            end
            e = qb.pop_front(); checks++;
            if ({v_b, r1_b, r2_b} !== e) begin
                errors++; $display("FAIL bypass_b k=%0d got v=%b %h %h exp v=%b %h %h", k, v_b, r1_b, r2_b, e.v, e.r1, e.r2);
            end
            e = qc.pop_front(); checks++;
            if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
                errors++; $display("FAIL bypass_c k=%0d got v=%b %h %h exp v=%b %h %h", k, v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
            end
        end
    endtask

    // Read r3 once, then rewrite it for three idle-read cycles: outputs hold, VALID drops
    task automatic test_hold;
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h33);
        for (int k = 0; k < 4; k++) begin
            qa.push_back('{(k == 0), 32'h33, 32'h33});
            qb.push_back('{(k == 0), 32'h33, 32'h33});
            qc.push_back('{(k == 0), 32'h33, 32'h33});
            if (k == 0) step(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
            else        step(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h40 + 32'(k));
            e = qa.pop_front(); checks++;
            if ({v_a, r1_a, r2_a} !== e) begin
                errors++; $display("FAIL hold_a k=%0d got v=%b %h %h exp v=%b %h %h", k, v_a, r1_a, r2_a, e.v, e.r1, e.r2);
            end
            e = qb.pop_front(); checks++;
            if ({v_b, r1_b, r2_b} !== e) begin
                errors++; $display("FAIL hold_b k=%0d got v=%b %h %h exp v=%b %h %h", k, v_b, r1_b, r2_b, e.v, e.r1, e.r2);
            end
            e = qc.pop_front(); checks++;
            if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
                errors++; $display("FAIL hold_c k=%0d got v=%b %h %h exp v=%b %h %h", k, v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h77);
        for (int k = 0; k < 2; k++) begin
            reset = (k != 0);
            qa.push_back((k == 0) ? '{1'b0, 32'h0, 32'h0} : '{1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5});
            qb.push_back((k == 0) ? '{1'b0, 32'h0, 32'h0} : '{1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5});
            qc.push_back((k == 0) ? '{1'b0, 32'h0, 32'h0} : '{1'b1, 32'h5A5A, 32'h5A5A});
            step(1'b1, (k == 0), 5'd9, 5'd9, 5'd9, 32'h99);
            e = qa.pop_front(); checks++;
            if ({v_a, r1_a, r2_a} !== e) begin
                errors++; $display("FAIL reset_mid_a k=%0d got v=%b %h %h exp v=%b %h %h", k, v_a, r1_a, r2_a, e.v, e.r1, e.r2);
            end
            e = qb.pop_front(); checks++;
            if ({v_b, r1_b, r2_b} !== e) begin
                errors++; $display("FAIL reset_mid_b k=%0d got v=%b %h %h exp v=%b %h %h", k, v_b, r1_b, r2_b, e.v, e.r1, e.r2);
            end
            e = qc.pop_front(); checks++;
            if ({v_c, r1_c, r2_c} !== {e.v, e.r1[15:0], e.r2[15:0]}) begin
                errors++; $display("FAIL reset_mid_c k=%0d got v=%b %h %h exp v=%b %h %h", k, v_c, r1_c, r2_c, e.v, e.r1[15:0], e.r2[15:0]);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        read    = 1'b0;
        write   = 1'b0;
        addr_r1 = '0;
        addr_r2 = '0;
        addr_wr = '0;
        data_in = '0;
        @(negedge clk);
        test_reset();
        test_sweep_wide();
        test_sweep_narrow();
        test_reg0();
        test_bypass();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
